sha_w_expander_stream: RTL

- Parametrised message-schedule expander for the SHA-2 pipeline.
- Accepts one 16-word block through a valid/ready handshake, then streams W[0]..W[ROUNDS-1], one word per handshake, to the compression round logic.
- Supports SHA-256 and SHA-512 word sizes.
- Implements the full recurrence: W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16].
- Intended as the general successor to the fixed-window, single-word memory stages.

---
 rtl/sha2_pkg.sv | 49 ++++
 rtl/sha_w_sigma.sv | 23 ++
 rtl/sha_w_expander_stream.sv | 93 +++++++++
 3 files changed

// File: rtl/sha2_pkg.sv
// Shared SHA-2 message-schedule definitions: FSM states, sigma rotation/shift
// amounts for SHA-256 and SHA-512, and the small sigma functions.
package sha2_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int S256_S0_R1 = 7;
  localparam int S256_S0_R2 = 18;
  localparam int S256_S0_SH = 3;
  localparam int S256_S1_R1 = 17;
  localparam int S256_S1_R2 = 19;
  localparam int S256_S1_SH = 10;

  localparam int S512_S0_R1 = 1;
  localparam int S512_S0_R2 = 8;
  localparam int S512_S0_SH = 7;
  localparam int S512_S1_R1 = 19;
  localparam int S512_S1_R2 = 61;
  localparam int S512_S1_SH = 6;

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // In SHA-256 mode only the low 32 bits of x are used and the result is zero-extended.
  function automatic logic [63:0] sigma0(input bit sha512, input logic [63:0] x);
    if (sha512)
      return rotr64(x, S512_S0_R1) ^ rotr64(x, S512_S0_R2) ^ (x >> S512_S0_SH);
    else
      return {32'h0, rotr32(x[31:0], S256_S0_R1) ^ rotr32(x[31:0], S256_S0_R2) ^
                     (x[31:0] >> S256_S0_SH)};
  endfunction

  function automatic logic [63:0] sigma1(input bit sha512, input logic [63:0] x);
    if (sha512)
      return rotr64(x, S512_S1_R1) ^ rotr64(x, S512_S1_R2) ^ (x >> S512_S1_SH);
    else
      return {32'h0, rotr32(x[31:0], S256_S1_R1) ^ rotr32(x[31:0], S256_S1_R2) ^
                     (x[31:0] >> S256_S1_SH)};
  endfunction

endpackage

// File: rtl/sha_w_sigma.sv
// Combinational next-word generator for the 16-entry schedule window:
// nxt = s1(w14) + w9 + s0(w1) + w0, modulo 2^WORD_W.
module sha_w_sigma
  import sha2_pkg::*;
#(
  parameter int SHA512 = 0,
  localparam int WORD_W = (SHA512 != 0) ? 64 : 32
) (
  input  logic [WORD_W-1:0] w0,
  input  logic [WORD_W-1:0] w1,
  input  logic [WORD_W-1:0] w9,
  input  logic [WORD_W-1:0] w14,
  output logic [WORD_W-1:0] nxt
);

  logic [WORD_W-1:0] s0;
  logic [WORD_W-1:0] s1;

  assign s0  = WORD_W'(sigma0(SHA512 != 0, 64'(w1)));
  assign s1  = WORD_W'(sigma1(SHA512 != 0, 64'(w14)));
  assign nxt = s1 + w9 + s0 + w0;

endmodule

// File: rtl/sha_w_expander_stream.sv
// SHA-2 message-schedule expander: accepts a 16-word block, streams W[0]..W[ROUNDS-1].
// Optional macro SHA_W_EARLY_LOAD_EN lets the next block load on the last-word handshake.
//
// Handshakes: a transfer happens on a rising CLK edge where valid and ready are
// both high; valid and its data hold until that edge; ready may depend on the
// other side only through in_ready <- out_ready when early load is enabled.
module sha_w_expander_stream
  import sha2_pkg::*;
#(
  parameter int SHA512 = 0,
  parameter int ROUNDS = 64,
  localparam int WORD_W = (SHA512 != 0) ? 64 : 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [16*WORD_W-1:0] block_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_W-1:0]    out_word,
  output logic [6:0]           out_t,
  output logic                 out_last,
  output state_e               dbg_state
);

  localparam logic [6:0] LAST_T = 7'(ROUNDS - 1);

  state_e            state;
  state_e            state_next;
  logic [WORD_W-1:0] win [16];
  logic [6:0]        t;
  logic [WORD_W-1:0] nxt;
  logic              accept;
  logic              at_last;

  assign at_last = (state == RUN) && (t == LAST_T);

`ifdef SHA_W_EARLY_LOAD_EN
  assign in_ready = (state == IDLE) || (at_last && out_ready);
`else
  assign in_ready = (state == IDLE);
`endif

  assign accept    = in_valid && in_ready;
  assign out_valid = (state == RUN);
  assign out_word  = win[0];
  assign out_t     = t;
  assign out_last  = at_last;
  assign dbg_state = state;

  sha_w_sigma #(.SHA512(SHA512)) u_sigma (
    .w0  (win[0]),
    .w1  (win[1]),
    .w9  (win[9]),
    .w14 (win[14]),
    .nxt (nxt)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = RUN;
      RUN:  if (at_last && out_ready) state_next = accept ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_next;
  end

  // A load always wins over the shift, which is what makes early load seamless.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      t <= '0;
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else if (accept) begin
      t <= '0;
      for (int i = 0; i < 16; i++) win[i] <= block_in[(15-i)*WORD_W +: WORD_W];
    end else if ((state == RUN) && out_ready) begin
      if (t == LAST_T) begin
        t <= '0;
      end else begin
        t <= t + 7'd1;
        for (int i = 0; i < 15; i++) win[i] <= win[i+1];
        win[15] <= nxt;
      end
    end
  end

endmodule
